sipo_frame_register: RTL and testbench

Serial-in/parallel-out frame capture stage that consumes the single-bit stream from the D_flip_flop output stage (its Q) and assembles WIDTH-bit words. A START pulse arms capture, and SIN_VALID qualifies each bit. A one-cycle FRAME_VALID pulse presents the completed word to downstream logic.

---
 rtl/sipo_frame_register.sv | 158 +++++++++++++++
 tb/tb_sipo_frame_register.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_register.sv
// sipo_frame_register: serial-in/parallel-out frame capture.
// START arms a capture, SIN_VALID qualifies each incoming bit, and a
// one-cycle FRAME_VALID presents the completed WIDTH-bit word on PAR_OUT.
// Optional feature macro: SIPO_PARITY_CHECK_EN (one extra even-parity bit
// per frame, result reported on PARITY_ERR).
module sipo_frame_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         SIN,
  input  logic                         SIN_VALID,
  input  logic                         START,
  output logic [WIDTH-1:0]             PAR_OUT,
  output logic                         FRAME_VALID,
  output logic                         BUSY,
  output logic [$clog2(WIDTH+1)-1:0]   BIT_CNT,
  output logic                         PARITY_ERR
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic             last_bit;

  // Insert one bit into the partial word; direction chosen by MSB_FIRST so
  // that the first received bit ends up in the requested position.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic             b);
    if (MSB_FIRST) begin
      return {sr[WIDTH-2:0], b};
    end
    return {b, sr[WIDTH-1:1]};
  endfunction

  assign last_bit = SIN_VALID && (BIT_CNT == LAST_IDX);

  // State register; reset has priority over everything else.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; any unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = START ? S_SHIFT : S_IDLE;
      S_SHIFT: begin
        if (last_bit) begin
`ifdef SIPO_PARITY_CHECK_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_SHIFT;
        end
      end
`ifdef SIPO_PARITY_CHECK_EN
      S_PARITY: state_nxt = SIN_VALID ? S_DONE : S_PARITY;
`endif
      S_DONE:  state_nxt = START ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded directly from the current state.
  always_comb begin
    FRAME_VALID = 1'b0;
    BUSY        = 1'b0;
    case (state)
      S_SHIFT:  BUSY = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
      S_PARITY: BUSY = 1'b1;
`endif
      S_DONE:   FRAME_VALID = 1'b1;
      default: begin
        FRAME_VALID = 1'b0;
        BUSY        = 1'b0;
      end
    endcase
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic parity_err_q;
  assign PARITY_ERR = parity_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  // Shift register, bit counter and output word; the output word only
  // changes on the edge that finishes a frame, so it holds between frames.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg    <= '0;
      PAR_OUT      <= '0;
      BIT_CNT      <= '0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            shift_reg <= '0;
            BIT_CNT   <= '0;
          end
        end
        S_SHIFT: begin
          if (SIN_VALID) begin
            shift_reg <= shift_in(shift_reg, SIN);
            BIT_CNT   <= BIT_CNT + 1'b1;
`ifndef SIPO_PARITY_CHECK_EN
            if (last_bit) begin
              PAR_OUT <= shift_in(shift_reg, SIN);
            end
`endif
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        // The full data word is already in shift_reg; the incoming bit is
        // the even-parity bit, so a nonzero XOR over both flags an error.
        S_PARITY: begin
          if (SIN_VALID) begin
            PAR_OUT      <= shift_reg;
            parity_err_q <= (^shift_reg) ^ SIN;
          end
        end
`endif
        S_DONE: begin
          BIT_CNT <= '0;
          if (START) begin
            shift_reg <= '0;
          end
        end
        default: begin
          BIT_CNT <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_register.sv
// Testbench for sipo_frame_register: two instances (MSB_FIRST=1 and 0)
// share the same stimulus; expected words come from an arithmetic model.
module tb_sipo_frame_register;

  localparam int W = 8;
`ifdef SIPO_PARITY_CHECK_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       CLK;
  logic       RST;
  logic       SIN;
  logic       SIN_VALID;
  logic       START;

  logic [7:0] po_m, po_l;
  logic       fv_m, fv_l, busy_m, busy_l, pe_m, pe_l;
  logic [3:0] bc_m, bc_l;

  int vectors;
  int miscompares;

  sipo_frame_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SIN_VALID(SIN_VALID), .START(START),
    .PAR_OUT(po_m), .FRAME_VALID(fv_m), .BUSY(busy_m), .BIT_CNT(bc_m),
    .PARITY_ERR(pe_m)
  );

  sipo_frame_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SIN_VALID(SIN_VALID), .START(START),
    .PAR_OUT(po_l), .FRAME_VALID(fv_l), .BUSY(busy_l), .BIT_CNT(bc_l),
    .PARITY_ERR(pe_l)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: seq holds bits in arrival order, seq[7] first. The i-th
  // arriving bit has weight 2^(W-1-i) for MSB-first, 2^i for LSB-first.
  function automatic logic [7:0] exp_word(input logic [7:0] seq, input bit msb);
    int acc;
    acc = 0;
    for (int i = 0; i < W; i++) begin
      if (seq[7-i]) acc += msb ? (1 << (W - 1 - i)) : (1 << i);
    end
    return acc[7:0];
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] seq, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      SIN = seq[7-i];
      SIN_VALID = 1'b1;
      cyc();
    end
    SIN_VALID = 1'b0;
  endtask

  task automatic send_parity(input logic p);
    if (PAR_BITS != 0) begin
      SIN = p;
      SIN_VALID = 1'b1;
      cyc();
      SIN_VALID = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      SIN = 1'($urandom_range(0, 1));
      START = 1'($urandom_range(0, 1));
      SIN_VALID = 1'($urandom_range(0, 1));
      cyc();
    end
    vectors++;
    if ({po_m, po_l, fv_m, fv_l, busy_m, busy_l, bc_m, bc_l, pe_m, pe_l} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got po=%h/%h fv=%b%b busy=%b%b bc=%0d/%0d pe=%b%b want all 0",
               po_m, po_l, fv_m, fv_l, busy_m, busy_l, bc_m, bc_l, pe_m, pe_l);
    end
    RST = 1'b0;
    START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      SIN = 1'($urandom_range(0, 1));
      SIN_VALID = 1'($urandom_range(0, 1));
      cyc();
      vectors++;
      if ({fv_m, fv_l, busy_m, busy_l} !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle_no_start cycle %0d got fv=%b%b busy=%b%b want 0000",
                 i, fv_m, fv_l, busy_m, busy_l);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] seq;
    seq = 8'b1011_0010;
    START = 1'b1;
    cyc();
    START = 1'b0;
    vectors++;
    if ({busy_m, busy_l, bc_m, bc_l} !== {2'b11, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL basic_armed got busy=%b%b bc=%0d/%0d want busy=11 bc=0",
               busy_m, busy_l, bc_m, bc_l);
    end
    send_bits(seq, 0, 7);
    vectors++;
    if ({bc_m, fv_m, busy_m} !== {4'd7, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_seven got bc=%0d fv=%b busy=%b want bc=7 fv=0 busy=1",
               bc_m, fv_m, busy_m);
    end
    send_bits(seq, 7, 8);
    send_parity(^seq);
    vectors++;
    if ({fv_m, fv_l, busy_m, busy_l} !== 4'b1100) begin
      miscompares++;
      $display("FAIL basic_done got fv=%b%b busy=%b%b want 1100", fv_m, fv_l, busy_m, busy_l);
    end
    vectors++;
    if (po_m !== 8'hB2 || po_l !== exp_word(seq, 1'b0)) begin
      miscompares++;
      $display("FAIL basic_word got %h/%h want b2/%h", po_m, po_l, exp_word(seq, 1'b0));
    end
    vectors++;
    if ({pe_m, bc_m} !== {1'b0, 4'd8}) begin
      miscompares++;
      $display("FAIL basic_pe_cnt got pe=%b bc=%0d want pe=0 bc=8", pe_m, bc_m);
    end
    cyc();
    vectors++;
    if ({fv_m, fv_l, busy_m, bc_m, po_m} !== {3'b000, 4'd0, 8'hB2}) begin
      miscompares++;
      $display("FAIL basic_after got fv=%b%b busy=%b bc=%0d po=%h want 000 0 b2",
               fv_m, fv_l, busy_m, bc_m, po_m);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] seq;
    seq = 8'b1011_0010;
    START = 1'b1;
    cyc();
    START = 1'b0;
    send_bits(seq, 0, 4);
    for (int g = 0; g < 3; g++) begin
      SIN_VALID = 1'b0;
      SIN = 1'($urandom_range(0, 1));
      START = (g == 1);
      cyc();
      vectors++;
      if ({bc_m, bc_l, busy_m, fv_m} !== {4'd4, 4'd4, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL gap_hold %0d got bc=%0d/%0d busy=%b fv=%b want 4/4 1 0",
                 g, bc_m, bc_l, busy_m, fv_m);
      end
    end
    START = 1'b0;
    send_bits(seq, 4, 8);
    send_parity(^seq);
    vectors++;
    if ({fv_m, fv_l, po_m, po_l} !== {2'b11, 8'hB2, exp_word(seq, 1'b0)}) begin
      miscompares++;
      $display("FAIL gap_word got fv=%b%b po=%h/%h want 11 b2/%h",
               fv_m, fv_l, po_m, po_l, exp_word(seq, 1'b0));
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1, f2;
    int gap;
    f1 = 8'b1000_0000;
    f2 = 8'b1111_0000;
    START = 1'b1;
    cyc();
    send_bits(f1, 0, 8);
    send_parity(^f1);
    vectors++;
    if ({fv_m, fv_l, po_m, po_l} !== {2'b11, 8'h80, 8'h01}) begin
      miscompares++;
      $display("FAIL b2b_frame1 got fv=%b%b po=%h/%h want 11 80/01", fv_m, fv_l, po_m, po_l);
    end
    gap = 0;
    SIN_VALID = 1'b0;
    cyc();
    gap++;
    vectors++;
    if ({busy_m, busy_l, fv_m, fv_l, bc_m} !== {4'b1100, 4'd0}) begin
      miscompares++;
      $display("FAIL b2b_rearm got busy=%b%b fv=%b%b bc=%0d want 1100 0",
               busy_m, busy_l, fv_m, fv_l, bc_m);
    end
    for (int i = 0; i < W + PAR_BITS; i++) begin
      SIN = (i < W) ? f2[7-i] : ^f2;
      SIN_VALID = 1'b1;
      cyc();
      if (i < W + PAR_BITS - 1) begin
        gap++;
        vectors++;
        if ({busy_m, fv_m} !== 2'b10) begin
          miscompares++;
          $display("FAIL b2b_between %0d got busy=%b fv=%b want 10", i, busy_m, fv_m);
        end
      end
    end
    SIN_VALID = 1'b0;
    vectors++;
    if ({fv_m, fv_l, po_m, po_l} !== {2'b11, 8'hF0, 8'h0F}) begin
      miscompares++;
      $display("FAIL b2b_frame2 got fv=%b%b po=%h/%h want 11 f0/0f", fv_m, fv_l, po_m, po_l);
    end
    vectors++;
    if (gap !== W + PAR_BITS) begin
      miscompares++;
      $display("FAIL b2b_spacing got %0d want %0d", gap, W + PAR_BITS);
    end
    START = 1'b0;
    cyc();
    vectors++;
    if ({fv_m, busy_m, po_l} !== {2'b00, 8'h0F}) begin
      miscompares++;
      $display("FAIL b2b_end got fv=%b busy=%b po=%h want 00 0f", fv_m, busy_m, po_l);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq;
    seq = 8'($urandom);
    START = 1'b1;
    cyc();
    START = 1'b0;
    send_bits(seq, 0, 5);
    RST = 1'b1;
    SIN_VALID = 1'b1;
    cyc();
    RST = 1'b0;
    SIN_VALID = 1'b0;
    vectors++;
    if ({busy_m, busy_l, bc_m, bc_l, po_m, po_l, fv_m} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid got busy=%b%b bc=%0d/%0d po=%h/%h fv=%b want all 0",
               busy_m, busy_l, bc_m, bc_l, po_m, po_l, fv_m);
    end
    START = 1'b1;
    cyc();
    START = 1'b0;
    send_bits(8'hFF, 0, 8);
    send_parity(1'b0);
    vectors++;
    if ({fv_m, po_m, po_l, pe_m} !== {1'b1, 8'hFF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_then_ff got fv=%b po=%h/%h pe=%b want 1 ff/ff 0", fv_m, po_m, po_l, pe_m);
    end
    cyc();
  endtask

`ifdef SIPO_PARITY_CHECK_EN
  task automatic test_parity();
    for (int k = 0; k < 2; k++) begin
      START = 1'b1;
      cyc();
      START = 1'b0;
      send_bits(8'hB2, 0, 8);
      vectors++;
      if ({busy_m, fv_m, bc_m} !== {2'b10, 4'd8}) begin
        miscompares++;
        $display("FAIL par_wait got busy=%b fv=%b bc=%0d want 1 0 8", busy_m, fv_m, bc_m);
      end
      send_parity(k[0]);
      vectors++;
      if ({fv_m, fv_l, pe_m, pe_l, po_m} !== {2'b11, k[0], k[0], 8'hB2}) begin
        miscompares++;
        $display("FAIL par_result %0d got fv=%b%b pe=%b%b po=%h want 11 %b%b b2",
                 k, fv_m, fv_l, pe_m, pe_l, po_m, k[0], k[0]);
      end
      cyc();
      vectors++;
      if ({fv_m, pe_m} !== {1'b0, k[0]}) begin
        miscompares++;
        $display("FAIL par_hold %0d got fv=%b pe=%b want 0 %b", k, fv_m, pe_m, k[0]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] seq;
    logic [7:0] held_m, held_l;
    logic       pbit, exp_pe;
    int         got, guard;
    for (int f = 0; f < 40; f++) begin
      seq = '0;
      START = 1'b1;
      SIN_VALID = 1'b0;
      cyc();
      vectors++;
      if ({busy_m, busy_l, bc_m} !== {2'b11, 4'd0}) begin
        miscompares++;
        $display("FAIL rnd_arm f%0d got busy=%b%b bc=%0d want 11 0", f, busy_m, busy_l, bc_m);
      end
      got = 0;
      guard = 0;
      while (got < W && guard < 200) begin
        SIN_VALID = 1'($urandom_range(0, 1));
        SIN = 1'($urandom_range(0, 1));
        START = 1'($urandom_range(0, 1));
        cyc();
        guard++;
        if (SIN_VALID) begin
          seq[7-got] = SIN;
          got++;
        end
        vectors++;
        if (got < W) begin
          if ({bc_m, bc_l, busy_m, fv_m} !== {4'(got), 4'(got), 2'b10}) begin
            miscompares++;
            $display("FAIL rnd_shift f%0d got bc=%0d/%0d busy=%b fv=%b want %0d 1 0",
                     f, bc_m, bc_l, busy_m, fv_m, got);
          end
        end else begin
          if ({bc_m, busy_m, fv_m} !== {4'd8, (PAR_BITS != 0), (PAR_BITS == 0)}) begin
            miscompares++;
            $display("FAIL rnd_last f%0d got bc=%0d busy=%b fv=%b", f, bc_m, busy_m, fv_m);
          end
        end
      end
      vectors++;
      if (got != W) begin
        miscompares++;
        $display("FAIL rnd_timeout f%0d got %0d bits want %0d", f, got, W);
      end
      pbit = 1'($urandom_range(0, 1));
      exp_pe = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      exp_pe = ^{seq, pbit};
      guard = 0;
      SIN_VALID = 1'b0;
      while (!SIN_VALID && guard < 50) begin
        SIN_VALID = 1'($urandom_range(0, 1));
        SIN = SIN_VALID ? pbit : 1'($urandom_range(0, 1));
        START = 1'($urandom_range(0, 1));
        cyc();
        guard++;
        if (!SIN_VALID) begin
          vectors++;
          if ({busy_m, fv_m, bc_m} !== {2'b10, 4'd8}) begin
            miscompares++;
            $display("FAIL rnd_parwait f%0d got busy=%b fv=%b bc=%0d", f, busy_m, fv_m, bc_m);
          end
        end
      end
      vectors++;
      if (!SIN_VALID) begin
        miscompares++;
        $display("FAIL rnd_par_timeout f%0d got no parity bit want one", f);
      end
`endif
      SIN_VALID = 1'b0;
      START = 1'b0;
      vectors++;
      if ({fv_m, fv_l, po_m, po_l, pe_m, pe_l} !==
          {2'b11, exp_word(seq, 1'b1), exp_word(seq, 1'b0), exp_pe, exp_pe}) begin
        miscompares++;
        $display("FAIL rnd_word f%0d got fv=%b%b po=%h/%h pe=%b%b want 11 %h/%h %b",
                 f, fv_m, fv_l, po_m, po_l, pe_m, pe_l,
                 exp_word(seq, 1'b1), exp_word(seq, 1'b0), exp_pe);
      end
      held_m = exp_word(seq, 1'b1);
      held_l = exp_word(seq, 1'b0);
      for (int j = 0; j < $urandom_range(1, 4); j++) begin
        SIN = 1'($urandom_range(0, 1));
        SIN_VALID = 1'($urandom_range(0, 1));
        cyc();
        vectors++;
        if ({fv_m, busy_m, po_m, po_l, pe_m} !== {2'b00, held_m, held_l, exp_pe}) begin
          miscompares++;
          $display("FAIL rnd_idle f%0d got fv=%b busy=%b po=%h/%h pe=%b want 00 %h/%h %b",
                   f, fv_m, busy_m, po_m, po_l, pe_m, held_m, held_l, exp_pe);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b1;
    SIN = 1'b0;
    SIN_VALID = 1'b0;
    START = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
`ifdef SIPO_PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
